// File: rtl/spike_wta_classifier.sv
// Winner-take-all readout for a spiking layer: counts output spikes per neuron over a window,
// then serially scans the counters for the maximum and holds the result until it is consumed.
module spike_wta_classifier #(
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WIN_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [WIN_W-1:0]               window_len,
  input  logic [NUM_NEURONS-1:0]         spike_in,
  output logic                           busy,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [$clog2(NUM_NEURONS)-1:0] winner_idx,
  output logic [CNT_W-1:0]               winner_count,
  output logic                           tie
);

  localparam int unsigned IdxW = $clog2(NUM_NEURONS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StCount, StCompare, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_NEURONS];
  logic [CNT_W-1:0]  cnt_d [NUM_NEURONS];
  logic [WIN_W-1:0]  rem_q, rem_d;
  logic [IdxW-1:0]   scan_q, scan_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic [IdxW-1:0]   max_idx_q, max_idx_d;
  logic              run_tie_q, run_tie_d;
  logic [IdxW-1:0]   win_idx_q, win_idx_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic              win_tie_q, win_tie_d;

  logic              accept;
  logic [CNT_W-1:0]  cur_cnt;
  logic [CNT_W-1:0]  cmp_max;
  logic [IdxW-1:0]   cmp_idx;
  logic              cmp_tie;

  assign accept  = (state_q == StIdle) && start && (window_len != '0);
  assign cur_cnt = cnt_q[scan_q];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StCount;
      StCount:   if (rem_q == WIN_W'(1)) state_d = StCompare;
      StCompare: if (scan_q == LastIdx) state_d = StDone;
      StDone:    if (result_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy         = (state_q != StIdle);
    result_valid = (state_q == StDone);
  end

  // One step of the running max; index 0 seeds it, and only a strictly larger count replaces it.
  always_comb begin
    cmp_max = max_q;
    cmp_idx = max_idx_q;
    cmp_tie = run_tie_q;
    if (scan_q == '0) begin
      cmp_max = cur_cnt;
      cmp_idx = '0;
      cmp_tie = 1'b0;
    end else if (cur_cnt > max_q) begin
      cmp_max = cur_cnt;
      cmp_idx = scan_q;
      cmp_tie = 1'b0;
    end else if (cur_cnt == max_q) begin
      cmp_tie = 1'b1;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    scan_d    = scan_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    run_tie_d = run_tie_q;
    win_idx_d = win_idx_q;
    win_cnt_d = win_cnt_q;
    win_tie_d = win_tie_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          for (int i = 0; i < NUM_NEURONS; i++) cnt_d[i] = '0;
          rem_d  = window_len;
          scan_d = '0;
        end
      end
      StCount: begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (spike_in[i] && (cnt_q[i] != CntMax)) cnt_d[i] = cnt_q[i] + 1'b1;
        end
        rem_d = rem_q - 1'b1;
      end
      StCompare: begin
        max_d     = cmp_max;
        max_idx_d = cmp_idx;
        run_tie_d = cmp_tie;
        scan_d    = scan_q + 1'b1;
        if (scan_q == LastIdx) begin
          win_idx_d = cmp_idx;
          win_cnt_d = cmp_max;
          win_tie_d = cmp_tie;
          scan_d    = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
      rem_q     <= '0;
      scan_q    <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      run_tie_q <= 1'b0;
      win_idx_q <= '0;
      win_cnt_q <= '0;
      win_tie_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      scan_q    <= scan_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      run_tie_q <= run_tie_d;
      win_idx_q <= win_idx_d;
      win_cnt_q <= win_cnt_d;
      win_tie_q <= win_tie_d;
    end
  end

  assign winner_idx   = win_idx_q;
  assign winner_count = win_cnt_q;
  assign tie          = win_tie_q;

endmodule

// File: doc/spike_wta_classifier.md
SPIKE_WTA_CLASSIFIER -- requirements
Module: spike_wta_classifier

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 8: number of neuron output spike lines observed (>=2).
REQ-002 SHALL have parameter CNT_W, default 8: width of per-neuron spike counters.
REQ-003 SHALL have parameter WIN_W, default 16: width of the observation-window length.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request to begin one classification window.
REQ-007 SHALL have port window_len  input  WIN_W  window length in cycles; sampled only when start is accepted.
REQ-008 SHALL have port spike_in  input  NUM_NEURONS  one output_spike line per LIF neuron in the layer.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port result_valid  output  1  result available.
REQ-011 SHALL have port result_ready  input  1  consumer accepts result.
REQ-012 SHALL have port winner_idx  output  $clog2(NUM_NEURONS)  index of the neuron with the highest spike count.
REQ-013 SHALL have port winner_count  output  CNT_W  spike count of winner_idx.
REQ-014 SHALL have port tie  output  1  another neuron's count equals winner_count.

Function
REQ-015 SHALL implement FSM states IDLE, COUNT, COMPARE, DONE.
REQ-016 IDLE: start=1 and window_len!=0 SHALL be accepted: clear all counters, load remaining-cycle counter with window_len, go to COUNT.
REQ-017 IDLE: start=1 with window_len==0 SHALL be ignored (stay IDLE, no output change).
REQ-018 start SHALL be ignored in COUNT, COMPARE and DONE.
REQ-019 COUNT: for exactly window_len rising edges after the accepting edge, each counter i SHALL increment by 1 when spike_in[i]=1.
REQ-020 Counters SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-021 After the last COUNT edge, FSM SHALL enter COMPARE; the remaining-cycle counter SHALL not underflow.
REQ-022 COMPARE: SHALL scan one neuron per cycle, index 0 to NUM_NEURONS-1, NUM_NEURONS cycles total; index 0 initialises the running max.
REQ-023 Replacement SHALL occur only on strictly greater count, so the lowest index wins ties.
REQ-024 tie SHALL be set if any scanned index other than the winner has a count equal to the final max; all-equal counts (including all-zero) give winner_idx=0, tie=1.
REQ-025 Spikes arriving in COMPARE, DONE or IDLE SHALL be ignored.
REQ-026 DONE: result_valid=1; winner_idx, winner_count and tie SHALL hold stable until the handshake.
REQ-027 Handshake SHALL complete on an edge with result_valid=1 and result_ready=1; FSM then SHALL return to IDLE and result_valid SHALL drop on the next cycle.
REQ-028 result_ready high before result_valid SHALL have no effect; holding result_ready high SHALL complete the handshake on the first DONE cycle.
REQ-029 Latency: result_valid SHALL first be high window_len+NUM_NEURONS cycles after the edge that accepted start.
REQ-030 winner_idx, winner_count and tie SHALL retain the last result in IDLE until the next COMPARE completes.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, all counters 0, busy=0, result_valid=0, winner_idx=0, winner_count=0, tie=0.
REQ-032 Reset asserted mid-COUNT, mid-COMPARE or in DONE SHALL discard the window; there SHALL be no result_valid after reset release without a new start.

Verification
REQ-033 Basic: window_len=10, spike_in[3] high 7 cycles, [5] high 4, others 0, result_ready=1 -> result_valid after 18 cycles, winner_idx=3, winner_count=7, tie=0.
REQ-034 Tie: window_len=5, neurons 2 and 6 each spike 3 times -> winner_idx=2, winner_count=3, tie=1.
REQ-035 Saturation: CNT_W=8, window_len=300, spike_in[1] constantly high -> winner_count=255, winner_idx=1.
REQ-036 Backpressure: result_ready=0 for 20 cycles in DONE -> outputs stable, start pulses ignored; result_ready=1 -> IDLE next cycle, busy=0.
REQ-037 Edge cases: start with window_len=0 -> busy stays 0; all-zero spikes over window_len=4 -> winner_idx=0, winner_count=0, tie=1.
REQ-038 Reset mid-COUNT at cycle 3 of window_len=10 -> busy=0, result_valid=0 immediately, no result after release until a new start.
